pwm_deadtime: RTL and testbench

Complementary-output stage that sits directly downstream of the PWM comparators and consumes `PWM1_OUT`/`PWM2_OUT`. For each channel it drives a high-side and a low-side gate signal. The two sides never overlap, and a programmable dead time separates every transition. An external active-low fault input forces all gates off and latches a sticky flag that software must clear.

---
 rtl/pwm_deadtime_if.sv | 40 ++++
 rtl/pwm_deadtime.sv | 166 ++++++++++++++++
 tb/tb_pwm_deadtime.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_deadtime_if.sv
// rtl/pwm_deadtime_if.sv - control and gate-drive bundle for the complementary dead-time stage
//
// Ports (signals carried by the interface):
//   en         stage enable, 0 forces every gate off
//   dt_rise    dead cycles before a high-side turn-on
//   dt_fall    dead cycles before a low-side turn-on
//   pwm1_in    channel 1 comparator output (combinational source)
//   pwm2_in    channel 2 comparator output (combinational source)
//   fault_n    asynchronous external break, active low
//   fault_clr  single-cycle pulse that clears the sticky fault flag
//   pwm1_h/l   channel 1 high/low-side gates
//   pwm2_h/l   channel 2 high/low-side gates
//   fault_flag sticky fault status
// master drives the controls and observes the gates; slave is the stage itself.
interface pwm_deadtime_if #(
  parameter int DT_WIDTH = 8
);
  logic                en;
  logic [DT_WIDTH-1:0] dt_rise;
  logic [DT_WIDTH-1:0] dt_fall;
  logic                pwm1_in;
  logic                pwm2_in;
  logic                fault_n;
  logic                fault_clr;
  logic                pwm1_h;
  logic                pwm1_l;
  logic                pwm2_h;
  logic                pwm2_l;
  logic                fault_flag;

  modport master (
    output en, dt_rise, dt_fall, pwm1_in, pwm2_in, fault_n, fault_clr,
    input  pwm1_h, pwm1_l, pwm2_h, pwm2_l, fault_flag
  );

  modport slave (
    input  en, dt_rise, dt_fall, pwm1_in, pwm2_in, fault_n, fault_clr,
    output pwm1_h, pwm1_l, pwm2_h, pwm2_l, fault_flag
  );
endinterface

// File: rtl/pwm_deadtime.sv
// rtl/pwm_deadtime.sv - two-channel complementary gate driver with dead time and fault latch
//
// Ports:
//   clk    single rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pwm_deadtime_if.slave: en, dt_rise, dt_fall, pwm1_in, pwm2_in,
//          fault_n, fault_clr in; pwm1_h, pwm1_l, pwm2_h, pwm2_l, fault_flag out
module pwm_deadtime #(
  parameter int DT_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  pwm_deadtime_if.slave  bus
);

  localparam int NCH = 2;
  localparam logic [DT_WIDTH-1:0] CNT_ONE = DT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_LOW     = 3'd1,
    S_DT_TO_H = 3'd2,
    S_HIGH    = 3'd3,
    S_DT_TO_L = 3'd4
  } state_t;

  // Comparator outputs are registered once before the FSMs see them.
  logic [NCH-1:0]      r_pwm_q;

  // Two-flop synchronizer; idles at 1 so reset never looks like a fault.
  logic                r_fault_s1;
  logic                r_fault_s2;
  logic                r_fault_flag;

  state_t              r_state     [NCH];
  state_t              w_state_nxt [NCH];
  logic [DT_WIDTH-1:0] r_cnt       [NCH];
  logic [DT_WIDTH-1:0] w_cnt_nxt   [NCH];
  logic [NCH-1:0]      w_h;
  logic [NCH-1:0]      w_l;

  logic                w_fault;
  logic                w_block;
  logic                w_rise_zero;
  logic                w_fall_zero;

  assign w_fault     = ~r_fault_s2;
  // A fresh synchronized fault blocks on the same edge it sets the flag.
  assign w_block     = w_fault | r_fault_flag | ~bus.en;
  assign w_rise_zero = (bus.dt_rise == '0);
  assign w_fall_zero = (bus.dt_fall == '0);

  // Input register, synchronizer and sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_q      <= '0;
      r_fault_s1   <= 1'b1;
      r_fault_s2   <= 1'b1;
      r_fault_flag <= 1'b0;
    end else begin
      r_pwm_q    <= {bus.pwm2_in, bus.pwm1_in};
      r_fault_s1 <= bus.fault_n;
      r_fault_s2 <= r_fault_s1;
      // Fault has priority over a coincident clear.
      if (w_fault) begin
        r_fault_flag <= 1'b1;
      end else if (bus.fault_clr) begin
        r_fault_flag <= 1'b0;
      end
    end
  end

  // Channel FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        r_state[ch] <= S_OFF;
        r_cnt[ch]   <= '0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        r_state[ch] <= w_state_nxt[ch];
        r_cnt[ch]   <= w_cnt_nxt[ch];
      end
    end
  end

  // Channel FSM next state. The dead-time inputs are only read when the
  // counter is loaded, so a change mid-interval waits for the next one.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      w_state_nxt[ch] = r_state[ch];
      w_cnt_nxt[ch]   = r_cnt[ch];
      if (w_block) begin
        w_state_nxt[ch] = S_OFF;
        w_cnt_nxt[ch]   = '0;
      end else begin
        case (r_state[ch])
          S_OFF, S_LOW: begin
            if (r_pwm_q[ch]) begin
              if (w_rise_zero) begin
                w_state_nxt[ch] = S_HIGH;
              end else begin
                w_state_nxt[ch] = S_DT_TO_H;
                w_cnt_nxt[ch]   = bus.dt_rise;
              end
            end else begin
              w_state_nxt[ch] = S_LOW;
            end
          end
          S_DT_TO_H: begin
            // Abort returns straight to LOW; the high side never conducted.
            if (!r_pwm_q[ch]) begin
              w_state_nxt[ch] = S_LOW;
            end else if (r_cnt[ch] == CNT_ONE) begin
              w_state_nxt[ch] = S_HIGH;
            end else begin
              w_cnt_nxt[ch] = r_cnt[ch] - CNT_ONE;
            end
          end
          S_HIGH: begin
            if (!r_pwm_q[ch]) begin
              if (w_fall_zero) begin
                w_state_nxt[ch] = S_LOW;
              end else begin
                w_state_nxt[ch] = S_DT_TO_L;
                w_cnt_nxt[ch]   = bus.dt_fall;
              end
            end
          end
          S_DT_TO_L: begin
            if (r_pwm_q[ch]) begin
              w_state_nxt[ch] = S_HIGH;
            end else if (r_cnt[ch] == CNT_ONE) begin
              w_state_nxt[ch] = S_LOW;
            end else begin
              w_cnt_nxt[ch] = r_cnt[ch] - CNT_ONE;
            end
          end
          default: begin
            w_state_nxt[ch] = S_OFF;
            w_cnt_nxt[ch]   = '0;
          end
        endcase
      end
    end
  end

  // Moore output decode: only HIGH and LOW drive a gate, so h and l are
  // mutually exclusive by construction.
  always_comb begin
    w_h = '0;
    w_l = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      w_h[ch] = (r_state[ch] == S_HIGH);
      w_l[ch] = (r_state[ch] == S_LOW);
    end
  end

  assign bus.pwm1_h     = w_h[0];
  assign bus.pwm1_l     = w_l[0];
  assign bus.pwm2_h     = w_h[1];
  assign bus.pwm2_l     = w_l[1];
  assign bus.fault_flag = r_fault_flag;

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb/tb_pwm_deadtime.sv - scoreboard bench for pwm_deadtime with a timestamp-based reference model
module tb_pwm_deadtime;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pwm_deadtime_if #(.DT_WIDTH(8)) u_if ();

  pwm_deadtime #(.DT_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected {pwm1_h, pwm1_l, pwm2_h, pwm2_l, fault_flag} per rising edge.
  logic [4:0] exp_q [$];

  // Reference model. Per channel: which side owns the bridge (0 none,
  // 1 low, 2 high), whether that side is lit, and if a hand-over is pending,
  // the absolute cycle at which the new side may turn on.
  int m_owner [2];
  bit m_lit   [2];
  bit m_pend  [2];
  int m_due   [2];
  bit m_q     [2];
  bit m_sync  [2];
  bit m_flag;
  int m_t;

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_owner[c] = 0;
      m_lit[c]   = 1'b0;
      m_pend[c]  = 1'b0;
      m_due[c]   = 0;
      m_q[c]     = 1'b0;
      m_sync[c]  = 1'b1;
    end
    m_flag = 1'b0;
  endfunction

  function automatic void model_step();
    bit f_now;
    bit blk;
    int want;
    int dead;
    f_now = !m_sync[1];
    blk   = f_now || m_flag || !u_if.en;
    for (int c = 0; c < 2; c++) begin
      want = m_q[c] ? 2 : 1;
      if (blk) begin
        m_owner[c] = 0;
        m_lit[c]   = 1'b0;
        m_pend[c]  = 1'b0;
      end else if (want == m_owner[c]) begin
        m_lit[c]  = 1'b1;
        m_pend[c] = 1'b0;
      end else if (m_owner[c] == 0 && want == 1) begin
        m_owner[c] = 1;
        m_lit[c]   = 1'b1;
        m_pend[c]  = 1'b0;
      end else if (!m_pend[c]) begin
        dead = (want == 2) ? int'(u_if.dt_rise) : int'(u_if.dt_fall);
        if (dead == 0) begin
          m_owner[c] = want;
          m_lit[c]   = 1'b1;
        end else begin
          m_pend[c] = 1'b1;
          m_due[c]  = m_t + dead;
          m_lit[c]  = 1'b0;
        end
      end else if (m_t == m_due[c]) begin
        m_owner[c] = want;
        m_lit[c]   = 1'b1;
        m_pend[c]  = 1'b0;
      end
    end
    if (f_now) m_flag = 1'b1;
    else if (u_if.fault_clr) m_flag = 1'b0;
    m_sync[1] = m_sync[0];
    m_sync[0] = u_if.fault_n;
    m_q[0]    = u_if.pwm1_in;
    m_q[1]    = u_if.pwm2_in;
    m_t++;
  endfunction

  function automatic logic [4:0] model_out();
    return {m_lit[0] && m_owner[0] == 2, m_lit[0] && m_owner[0] == 1,
            m_lit[1] && m_owner[1] == 2, m_lit[1] && m_owner[1] == 1, m_flag};
  endfunction

  // Model: advances on every rising edge and pushes the expectation.
  initial begin
    m_t = 0;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      exp_q.push_back(model_out());
    end
  end

  // Monitor: samples the gates 1 time unit after each edge.
  initial begin
    logic [4:0] got;
    logic [4:0] exp;
    forever begin
      @(posedge clk);
      #1;
      got = {u_if.pwm1_h, u_if.pwm1_l, u_if.pwm2_h, u_if.pwm2_l, u_if.fault_flag};
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty t=%0t got=%b required=an expectation", $time, got);
      end else begin
        exp = exp_q.pop_front();
        if (got === exp) n_pass++;
        else $display("FAIL gates t=%0t got=%b required=%b (h1 l1 h2 l2 flag)", $time, got, exp);
      end
      n_chk++;
      if (!(got[4] && got[3]) && !(got[2] && got[1])) n_pass++;
      else $display("FAIL overlap t=%0t got=%b required=no h&l", $time, got);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    u_if.en        = 1'b0;
    u_if.dt_rise   = 8'd0;
    u_if.dt_fall   = 8'd0;
    u_if.pwm1_in   = 1'b0;
    u_if.pwm2_in   = 1'b0;
    u_if.fault_n   = 1'b1;
    u_if.fault_clr = 1'b0;
    rst_n          = 1'b0;
    cyc(3);
    u_if.en = 1'b1;
    rst_n   = 1'b1;
    cyc(4);

    // 50% duty, 40-cycle period, asymmetric dead times.
    u_if.dt_rise = 8'd3;
    u_if.dt_fall = 8'd5;
    u_if.pwm2_in = 1'b1;
    for (int p = 0; p < 2; p++) begin
      u_if.pwm1_in = 1'b1; cyc(20);
      u_if.pwm1_in = 1'b0; cyc(20);
    end

    // Pulse shorter than the rise dead time.
    u_if.dt_rise = 8'd10;
    u_if.pwm1_in = 1'b1; cyc(4);
    u_if.pwm1_in = 1'b0; cyc(20);

    // Zero dead time with random toggling.
    u_if.dt_rise = 8'd0;
    u_if.dt_fall = 8'd0;
    for (int i = 0; i < 40; i++) begin
      u_if.pwm1_in = 1'($urandom_range(0, 1));
      u_if.pwm2_in = 1'($urandom_range(0, 1));
      cyc(1);
    end

    // Dead time changed during an interval.
    u_if.dt_rise = 8'd2;
    u_if.dt_fall = 8'd2;
    u_if.pwm1_in = 1'b0; cyc(10);
    u_if.pwm1_in = 1'b1; cyc(2);
    u_if.dt_rise = 8'd7; cyc(10);
    u_if.pwm1_in = 1'b0; cyc(10);
    u_if.pwm1_in = 1'b1; cyc(15);

    // Fault while pwm2_h is on, clear while still faulted, then real clear.
    u_if.pwm2_in = 1'b1; cyc(10);
    u_if.fault_n = 1'b0; cyc(1);
    u_if.fault_n = 1'b1; cyc(5);
    u_if.fault_n = 1'b0; cyc(3);
    u_if.fault_clr = 1'b1; cyc(1);
    u_if.fault_clr = 1'b0; cyc(2);
    u_if.fault_n = 1'b1; cyc(4);
    u_if.fault_clr = 1'b1; cyc(1);
    u_if.fault_clr = 1'b0; cyc(15);

    // Two channels steady, then enable toggle.
    u_if.dt_rise = 8'd4;
    u_if.dt_fall = 8'd4;
    u_if.pwm1_in = 1'b1;
    u_if.pwm2_in = 1'b0; cyc(20);
    u_if.en = 1'b0; cyc(3);
    u_if.en = 1'b1; cyc(15);

    // Asynchronous reset in the middle of a dead interval.
    u_if.pwm1_in = 1'b0; cyc(3);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({u_if.pwm1_h, u_if.pwm1_l, u_if.pwm2_h, u_if.pwm2_l, u_if.fault_flag} === 5'b0) n_pass++;
    else $display("FAIL async_reset got=%b required=00000",
                  {u_if.pwm1_h, u_if.pwm1_l, u_if.pwm2_h, u_if.pwm2_l, u_if.fault_flag});
    cyc(2);
    rst_n = 1'b1; cyc(6);

    // Randomized operation.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) u_if.pwm1_in = ~u_if.pwm1_in;
      if ($urandom_range(0, 7) == 0) u_if.pwm2_in = ~u_if.pwm2_in;
      if ($urandom_range(0, 31) == 0) u_if.dt_rise = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0) u_if.dt_fall = 8'($urandom_range(0, 6));
      u_if.en        = ($urandom_range(0, 63) != 0);
      u_if.fault_n   = ($urandom_range(0, 199) != 0);
      u_if.fault_clr = ($urandom_range(0, 15) == 0);
      cyc(1);
    end

    u_if.fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
